hub75_receiver: RTL and testbench
=================================

HUB75_RECEIVER -- requirements
Module: hub75_receiver

Interface
REQ-001 SHALL have parameter COLS, default 64, columns per row segment (power of 2, 8..256).
REQ-002 SHALL have parameter ONTIME_W, default 16, on-time counter width.
REQ-003 SHALL have ports: clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1  input  1 each  panel data lines, asynchronous to clk.
REQ-006 SHALL have ports: panel_pa1..panel_pa4  input  1 each  row address, pa1 = LSB.
REQ-007 SHALL have ports: panel_sclk, panel_latch, panel_blank  input  1 each  panel shift clock, latch, blank (blank high = LEDs off).
REQ-008 SHALL have ports: pix_valid  output  1; pix_ready  input  1; pix_row  output  4; pix_col  output  log2(COLS); pix_plane  output  3; pix_rgb  output  6  {r1,g1,b1,r0,g0,b0}.
REQ-009 SHALL have ports: on_valid  output  1; on_time  output  ONTIME_W; on_row  output  4; on_plane  output  3.
REQ-010 SHALL have ports: err_col  output  1; err_overrun  output  1  single-cycle error pulses.

Function
REQ-011 SHALL pass every panel_* input through a 2-flop synchronizer; all further logic SHALL use synchronized copies only.
REQ-012 SHALL detect sclk and latch rising edges, and blank rising and falling edges, by comparing the synchronized value with a third registered copy.
REQ-013 SHALL write the six synchronized data bits into capture[col_cnt] on each sclk rising edge, then increment col_cnt; col_cnt SHALL saturate at COLS, with further edges ignored.
REQ-014 On a latch rising edge, SHALL copy capture into hold, latch the address, compute the plane, pulse err_col if col_cnt != COLS, and clear col_cnt to 0.
REQ-015 Plane SHALL be 0 if no row has been latched since reset or the address differs from the previous latched address; otherwise it SHALL be previous plane + 1, mod 8.
REQ-016 FSM states SHALL be IDLE and EMIT. The FSM SHALL go IDLE->EMIT on a latch edge, and EMIT->IDLE on the handshake of col COLS-1.
REQ-017 In EMIT, pix_valid SHALL be 1, with pix_col the emit index, pix_rgb = hold[index], and pix_row/pix_plane from the latch. The index SHALL advance only when pix_valid && pix_ready.
REQ-018 While pix_valid && !pix_ready, all pix_* outputs SHALL hold stable.
REQ-019 Latency: latch first high at the input flops on edge E0 -> pix_valid = 1 after edge E3 with pix_col = 0. With pix_ready held 1, COLS consecutive valid cycles SHALL follow.
REQ-020 A latch edge during EMIT SHALL pulse err_overrun, replace hold/row/plane, and restart emission at col 0. The current word SHALL be abandoned.
REQ-021 An sclk edge and a latch edge in the same cycle SHALL write that sample to capture first; the copy into hold SHALL include it.
REQ-022 Input timing requirement: sclk high and low each >= 2 clk periods; data and address stable >= 3 clk periods around the sclk rising edge. Behaviour outside these limits is undefined.

Reset
REQ-023 rst SHALL force FSM = IDLE and clear col_cnt, emit index, plane and the "row latched" flag.
REQ-024 On rst, all outputs SHALL go to 0, and synchronizer/edge regs SHALL go to 0 except the blank chain, which SHALL go to 1.
REQ-025 rst asserted mid-EMIT SHALL drop pix_valid on the next cycle, with no further words emitted.
REQ-026 The capture/hold arrays SHALL need no reset.

Configuration
REQ-027 Macro HUB75_RECEIVER_ONTIME_EN SHALL compile the on-time measurement in or out.
REQ-028 With HUB75_RECEIVER_ONTIME_EN defined:
- counter SHALL clear on blank falling edge and count cycles while blank is low, saturating at all-ones;
- on blank rising edge, on_valid SHALL pulse one cycle, with on_time = count and on_row/on_plane = last latched row/plane.
REQ-029 Without HUB75_RECEIVER_ONTIME_EN, on_valid, on_time, on_row and on_plane SHALL be constant 0, with no counter logic present.

Verification
REQ-030 Reset, then shift 64 columns, col i rgb = i[5:0], address 5, then latch; pix_ready = 1 -> 64 words col 0..63, rgb = col, row 5, plane 0, first valid 3 edges after latch sampled, no errors.
REQ-031 Three latches on row 5, then one on row 6 -> planes 0, 1, 2, then 0.
REQ-032 Shift only 60 columns, then latch -> err_col pulses once; the 64 words are still emitted.
REQ-033 pix_ready low for 5 cycles at col 10 -> col 10 held stable for 5 cycles; sequence completes without gaps or duplicates.
REQ-034 Second latch while col 20 of the first row is pending -> err_overrun pulse; emission restarts at col 0 with the new row data.
REQ-035 With HUB75_RECEIVER_ONTIME_EN, blank low for 100 cycles -> on_valid pulse with on_time = 100. Without the macro, on_valid stays 0.

Source files
------------

// File: rtl/hub75_receiver.sv
// hub75_receiver: snoops a HUB75 panel bus and replays each latched row as a handshaked pixel stream.
// Define HUB75_RECEIVER_ONTIME_EN to build in the blank-low on-time measurement.
module hub75_receiver #(
  parameter int COLS = 64,
  parameter int ONTIME_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    panel_r0,
  input  logic                    panel_g0,
  input  logic                    panel_b0,
  input  logic                    panel_r1,
  input  logic                    panel_g1,
  input  logic                    panel_b1,
  input  logic                    panel_pa1,
  input  logic                    panel_pa2,
  input  logic                    panel_pa3,
  input  logic                    panel_pa4,
  input  logic                    panel_sclk,
  input  logic                    panel_latch,
  input  logic                    panel_blank,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [3:0]              pix_row,
  output logic [$clog2(COLS)-1:0] pix_col,
  output logic [2:0]              pix_plane,
  output logic [5:0]              pix_rgb,
  output logic                    on_valid,
  output logic [ONTIME_W-1:0]     on_time,
  output logic [3:0]              on_row,
  output logic [2:0]              on_plane,
  output logic                    err_col,
  output logic                    err_overrun
);
  localparam int CW = $clog2(COLS);
  localparam logic [CW:0] CMAX = (CW+1)'(COLS);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [11:0] raw, s1_q, s2_q;
  logic [1:0] s3_q;
  logic sclk_e_q, latch_e_q;
  logic [5:0] data_q;
  logic [3:0] addr_q;
  logic [5:0] cap_q [COLS];
  logic [5:0] hold_q [COLS];
  logic [CW:0] col_cnt_q, col_cnt_d, cnt_inc;
  logic [CW-1:0] idx_q, idx_d;
  logic [3:0] row_q, row_d;
  logic [2:0] plane_q, plane_d;
  logic seen_q, err_col_q, err_ovr_q, cnt_wr, hs;
  assign raw = {panel_latch, panel_sclk, panel_pa4, panel_pa3, panel_pa2, panel_pa1,
                panel_r1, panel_g1, panel_b1, panel_r0, panel_g0, panel_b0};
  // Edges and the data sampled with them are registered together so a capture sees a consistent word
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      sclk_e_q <= 1'b0;
      latch_e_q <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      s3_q <= s2_q[11:10];
      sclk_e_q <= s2_q[10] & ~s3_q[0];
      latch_e_q <= s2_q[11] & ~s3_q[1];
      data_q <= s2_q[5:0];
      addr_q <= s2_q[9:6];
    end
  end
  always_comb begin
    cnt_wr = sclk_e_q && col_cnt_q != CMAX;
    cnt_inc = col_cnt_q + (CW+1)'(cnt_wr);
    hs = state_q == EMIT && pix_ready;
    col_cnt_d = latch_e_q ? '0 : cnt_inc;
    idx_d = latch_e_q ? '0 : hs ? idx_q + CW'(1) : idx_q;
    state_d = latch_e_q ? EMIT : (hs && idx_q == CW'(COLS-1)) ? IDLE : state_q;
    row_d = latch_e_q ? addr_q : row_q;
    plane_d = !latch_e_q ? plane_q : (seen_q && addr_q == row_q) ? plane_q + 3'd1 : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_cnt_q <= '0;
      idx_q <= '0;
      row_q <= '0;
      plane_q <= '0;
      seen_q <= 1'b0;
      err_col_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_cnt_q <= col_cnt_d;
      idx_q <= idx_d;
      row_q <= row_d;
      plane_q <= plane_d;
      seen_q <= seen_q | latch_e_q;
      err_col_q <= latch_e_q && cnt_inc != CMAX;
      err_ovr_q <= latch_e_q && state_q == EMIT;
    end
  end
  // A shift and a latch in the same cycle forward the new sample straight into hold
  always_ff @(posedge clk) begin
    for (int i = 0; i < COLS; i++) begin
      if (cnt_wr && col_cnt_q == (CW+1)'(i)) cap_q[i] <= data_q;
      if (latch_e_q) hold_q[i] <= (cnt_wr && col_cnt_q == (CW+1)'(i)) ? data_q : cap_q[i];
    end
  end
  assign pix_valid = state_q == EMIT;
  assign pix_col = idx_q;
  assign pix_row = row_q;
  assign pix_plane = plane_q;
  assign pix_rgb = pix_valid ? hold_q[idx_q] : 6'd0;
  assign err_col = err_col_q;
  assign err_overrun = err_ovr_q;
`ifdef HUB75_RECEIVER_ONTIME_EN
  logic bl1_q, bl2_q, bl3_q, on_valid_q;
  logic [ONTIME_W-1:0] cnt_q, cnt_d, on_time_q;
  logic [3:0] on_row_q;
  logic [2:0] on_plane_q;
  always_comb cnt_d = (bl3_q && !bl2_q) ? '0 : (!bl3_q && !(&cnt_q)) ? cnt_q + ONTIME_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      bl1_q <= 1'b1;
      bl2_q <= 1'b1;
      bl3_q <= 1'b1;
      cnt_q <= '0;
      on_valid_q <= 1'b0;
      on_time_q <= '0;
      on_row_q <= '0;
      on_plane_q <= '0;
    end else begin
      bl1_q <= panel_blank;
      bl2_q <= bl1_q;
      bl3_q <= bl2_q;
      cnt_q <= cnt_d;
      on_valid_q <= bl2_q && !bl3_q;
      on_time_q <= (bl2_q && !bl3_q) ? cnt_d : on_time_q;
      on_row_q <= (bl2_q && !bl3_q) ? row_q : on_row_q;
      on_plane_q <= (bl2_q && !bl3_q) ? plane_q : on_plane_q;
    end
  end
  assign on_valid = on_valid_q;
  assign on_time = on_time_q;
  assign on_row = on_row_q;
  assign on_plane = on_plane_q;
`else
  assign on_valid = 1'b0;
  assign on_time = '0;
  assign on_row = '0;
  assign on_plane = '0;
`endif
endmodule

// File: tb/tb_hub75_receiver.sv
// tb_hub75_receiver: row vectors plus scoreboard of emitted pixel words, with stall/overrun/reset/on-time sequences.
module tb_hub75_receiver;
  logic clk = 1'b0, rst = 1'b1;
  logic panel_r0 = 0, panel_g0 = 0, panel_b0 = 0, panel_r1 = 0, panel_g1 = 0, panel_b1 = 0;
  logic panel_pa1 = 0, panel_pa2 = 0, panel_pa3 = 0, panel_pa4 = 0;
  logic panel_sclk = 0, panel_latch = 0, panel_blank = 1, pix_ready = 1;
  logic pix_valid, on_valid, err_col, err_overrun;
  logic [3:0] pix_row, on_row;
  logic [5:0] pix_col, pix_rgb;
  logic [2:0] pix_plane, on_plane;
  logic [15:0] on_time;
  int checks = 0, failures = 0, n_errcol = 0, n_ovr = 0, n_on = 0, mcnt = 0;
  typedef struct {logic [5:0] col; logic [5:0] rgb; logic [3:0] row; logic [2:0] plane;} word_t;
  typedef struct {logic [3:0] addr; int ncols; int seed; logic [2:0] plane; int errcol;} vec_t;
  word_t exp_q[$];
  logic [5:0] cap_m [64];
  vec_t vt [6];

  hub75_receiver dut (
    .clk(clk), .rst(rst),
    .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
    .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
    .panel_pa1(panel_pa1), .panel_pa2(panel_pa2), .panel_pa3(panel_pa3), .panel_pa4(panel_pa4),
    .panel_sclk(panel_sclk), .panel_latch(panel_latch), .panel_blank(panel_blank),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_row(pix_row), .pix_col(pix_col),
    .pix_plane(pix_plane), .pix_rgb(pix_rgb),
    .on_valid(on_valid), .on_time(on_time), .on_row(on_row), .on_plane(on_plane),
    .err_col(err_col), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (err_col) n_errcol++;
      if (err_overrun) n_ovr++;
      if (on_valid) n_on++;
      if (pix_valid && pix_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected actual col=%0d rgb=%0h required=none", pix_col, pix_rgb);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          if ({pix_col, pix_rgb, pix_row, pix_plane} !== {e.col, e.rgb, e.row, e.plane}) begin
            failures++;
            $display("FAIL word actual col=%0d rgb=%0h row=%0d plane=%0d required col=%0d rgb=%0h row=%0d plane=%0d",
                     pix_col, pix_rgb, pix_row, pix_plane, e.col, e.rgb, e.row, e.plane);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic shift(input logic [5:0] d);
    {panel_r1, panel_g1, panel_b1, panel_r0, panel_g0, panel_b0} = d;
    repeat (3) @(posedge clk);
    #1 panel_sclk = 1'b1;
    repeat (3) @(posedge clk);
    #1 panel_sclk = 1'b0;
    if (mcnt < 64) cap_m[mcnt] = d;
    mcnt++;
  endtask

  task automatic push_row(input logic [3:0] a, input logic [2:0] p);
    for (int i = 0; i < 64; i++) exp_q.push_back('{6'(i), cap_m[i], a, p});
  endtask

  task automatic do_latch(input logic [3:0] a, input bit lat);
    {panel_pa4, panel_pa3, panel_pa2, panel_pa1} = a;
    repeat (3) @(posedge clk);
    #1 panel_latch = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (lat) chk("latency_pre", {31'd0, pix_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (lat) chk("latency_first", {25'd0, pix_valid, pix_col}, {25'd0, 1'b1, 6'd0});
    @(posedge clk);
    #1 panel_latch = 1'b0;
    mcnt = 0;
  endtask

  task automatic drain(input int exp_vc);
    int t = 0, vc = 0;
    while ((exp_q.size() != 0 || pix_valid) && t < 3000) begin
      @(negedge clk);
      if (pix_valid) vc++;
      t++;
    end
    chk("drain", exp_q.size(), 0);
    if (exp_vc >= 0) chk("valid_run", vc, exp_vc);
  endtask

  task automatic wait_col(input logic [5:0] c);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(pix_valid && pix_col == c) && t < 500);
    chk("wait_col", {31'd0, pix_valid && pix_col == c}, 32'd1);
  endtask

  initial begin
    int b;
    logic bad;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_pix", {pix_valid, pix_col, pix_rgb, pix_row, pix_plane}, '0);
    chk("rst_err", {err_col, err_overrun}, '0);
    chk("rst_on", {on_valid, on_time, on_row, on_plane}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    vt[0] = '{4'd5, 64, 0, 3'd0, 0};
    vt[1] = '{4'd5, 64, 7, 3'd1, 0};
    vt[2] = '{4'd5, 64, 21, 3'd2, 0};
    vt[3] = '{4'd6, 64, 33, 3'd0, 0};
    vt[4] = '{4'd6, 60, 50, 3'd1, 1};
    vt[5] = '{4'd15, 66, 3, 3'd0, 0};
    for (int v = 0; v < 6; v++) begin
      b = n_errcol;
      for (int i = 0; i < vt[v].ncols; i++) shift(6'(i + vt[v].seed));
      push_row(vt[v].addr, vt[v].plane);
      do_latch(vt[v].addr, 1'b1);
      drain(63);
      chk("err_col", n_errcol - b, vt[v].errcol);
    end
    chk("no_overrun", n_ovr, 0);
    for (int i = 0; i < 64; i++) shift(6'(i * 3));
    push_row(4'd3, 3'd0);
    do_latch(4'd3, 1'b1);
    wait_col(6'd9);
    @(posedge clk);
    #1 pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold", {pix_valid, pix_col, pix_rgb, pix_row, pix_plane}, {1'b1, 6'd10, cap_m[10], 4'd3, 3'd0});
    end
    @(posedge clk);
    #1 pix_ready = 1'b1;
    drain(-1);
    for (int i = 0; i < 64; i++) shift(6'(i ^ 21));
    push_row(4'd7, 3'd0);
    do_latch(4'd7, 1'b1);
    wait_col(6'd19);
    @(posedge clk);
    #1 pix_ready = 1'b0;
    b = n_ovr;
    for (int i = 0; i < 64; i++) shift(6'(63 - i));
    do_latch(4'd8, 1'b0);
    chk("overrun_pulse", n_ovr - b, 1);
    chk("overrun_restart", {pix_valid, pix_col, pix_rgb, pix_row, pix_plane}, {1'b1, 6'd0, cap_m[0], 4'd8, 3'd0});
    exp_q.delete();
    push_row(4'd8, 3'd0);
    pix_ready = 1'b1;
    drain(-1);
    for (int i = 0; i < 64; i++) shift(6'(i + 40));
    push_row(4'd8, 3'd1);
    do_latch(4'd8, 1'b1);
    wait_col(6'd5);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_emit", {pix_valid, pix_col, pix_rgb, pix_plane}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    mcnt = 0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (pix_valid) bad = 1'b1;
    end
    chk("rst_no_words", {31'd0, bad}, 32'd0);
    for (int i = 0; i < 64; i++) shift(6'(i * 5));
    push_row(4'd8, 3'd0);
    do_latch(4'd8, 1'b1);
    drain(63);
    b = n_on;
    repeat (2) @(posedge clk);
    #1 panel_blank = 1'b0;
    repeat (100) @(posedge clk);
    #1 panel_blank = 1'b1;
`ifdef HUB75_RECEIVER_ONTIME_EN
    for (int t = 0; t < 10 && !on_valid; t++) @(negedge clk);
    chk("on_valid", {31'd0, on_valid}, 32'd1);
    chk("on_time", {16'd0, on_time}, 32'd100);
    chk("on_row_plane", {on_row, on_plane}, {4'd8, 3'd0});
`else
    repeat (10) @(negedge clk);
    chk("on_valid_off", n_on - b, 0);
    chk("on_time_off", {16'd0, on_time}, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
